// File: rtl/dw_stack_arb_pkg.sv
// Purpose : shared constants for the stack arbiter slice (FSM encoding, op codes, clog2).
// Latency : n/a (package only).
// Backpr. : n/a (package only).
package dw_stack_arb_pkg;

    // FSM state encoding; kept as plain vectors so older code can compare against them
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    // Requester op encoding
    localparam logic OP_PUSH = 1'b1;
    localparam logic OP_POP  = 1'b0;

    // Ceiling log2; clog2(1) = 0, clog2(5) = 3
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dw_stack_arbiter_if.sv
// Purpose : requester-side bundle of the stack arbiter (requests, op, data, completion).
// Latency : n/a (wiring only).
// Backpr. : req is held by the client until its one-cycle ack pulse.
// Ports   : req/op/wdata driven by clients (master); ack/rsp_err/rdata driven by arbiter (slave).
interface dw_stack_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       op;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       ack;
    logic                  rsp_err;
    logic [WIDTH-1:0]      rdata;

    modport master (
        output req, op, wdata,
        input  ack, rsp_err, rdata
    );

    modport slave (
        input  req, op, wdata,
        output ack, rsp_err, rdata
    );
endinterface

// File: rtl/dw_rr_pick.sv
// Purpose : round-robin priority picker, first set req after rr_ptr (wrapping).
// Latency : combinational.
// Backpr. : none; caller decides when to consume the winner.
// Ports   : req (NREQ) + rr_ptr in; winner index + any_vld out.
module dw_rr_pick
    import dw_stack_arb_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    output logic [IW-1:0]   winner,
    output logic            any_vld
);

    logic found;

    // Search rr_ptr+1, rr_ptr+2, ... so the last winner has lowest priority
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && req[(int'(rr_ptr) + k) % NREQ]) begin
                found  = 1'b1;
                winner = IW'((int'(rr_ptr) + k) % NREQ);
            end
        end
    end

    assign any_vld = |req;

endmodule

// File: rtl/dw_stack_arbiter.sv
// Purpose : round-robin share of one DW_stack-style stack, screens overflow/underflow.
// Latency : 3 cycles per transaction (IDLE pick, ISSUE stack strobe, RESP ack).
// Backpr. : clients hold req until ack; losers simply wait, at most NREQ-1 transactions.
// Ports   : clk/rst; bus (slave modport: req/op/wdata in, ack/rsp_err/rdata out);
//           busy, level, protocol_err status; stk_* lines to/from the shared stack.
module dw_stack_arbiter
    import dw_stack_arb_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int IW    = clog2(NREQ),
    localparam int LW    = clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    dw_stack_arbiter_if.slave    bus,
    output logic                 busy,
    output logic [LW-1:0]        level,
    output logic                 stk_push_req_n,
    output logic                 stk_pop_req_n,
    output logic [WIDTH-1:0]     stk_data_in,
    input  logic [WIDTH-1:0]     stk_data_out,
    input  logic                 stk_empty,
    input  logic                 stk_full,
    input  logic                 stk_error,
    output logic                 protocol_err
);

    logic [1:0]       state;
    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    win_q;
    logic             op_q;
    logic [WIDTH-1:0] wdat_q;
    logic [WIDTH-1:0] rdata_q;
    logic             reject_q;
    logic [LW-1:0]    level_q;
    logic             perr_q;

    logic [IW-1:0]    pick_idx;
    logic             pick_vld;
    logic             in_issue;
    logic             reject;
    logic             lvl_mismatch;

    dw_rr_pick #(.NREQ(NREQ)) u_pick (
        .req     (bus.req),
        .rr_ptr  (rr_ptr),
        .winner  (pick_idx),
        .any_vld (pick_vld)
    );

    assign in_issue = (state == ST_ISSUE);

    // Flags are read live in ISSUE; the IDLE gap guarantees the previous strobe has landed
    assign reject = (op_q == OP_PUSH) ? stk_full : stk_empty;

    // Stack strobes are combinational from state so reset releases them immediately
    assign stk_push_req_n = !(in_issue && (op_q == OP_PUSH) && !reject);
    assign stk_pop_req_n  = !(in_issue && (op_q == OP_POP)  && !reject);
    assign stk_data_in    = (in_issue && !reject) ? wdat_q : '0;

    assign bus.ack     = (state == ST_RESP) ? ({{(NREQ-1){1'b0}}, 1'b1} << win_q) : '0;
    assign bus.rsp_err = (state == ST_RESP) && reject_q;
    assign bus.rdata   = (state == ST_RESP) ? rdata_q : '0;

    assign busy         = (state != ST_IDLE);
    assign level        = level_q;
    assign protocol_err = perr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            rr_ptr   <= IW'(NREQ - 1);
            win_q    <= '0;
            op_q     <= OP_POP;
            wdat_q   <= '0;
            rdata_q  <= '0;
            reject_q <= 1'b0;
            level_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        win_q  <= pick_idx;
                        op_q   <= bus.op[pick_idx];
                        wdat_q <= bus.wdata[pick_idx*WIDTH +: WIDTH];
                        state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    reject_q <= reject;
                    rr_ptr   <= win_q;
                    rdata_q  <= (!reject && (op_q == OP_POP)) ? stk_data_out : '0;
                    // Gating by full/empty keeps level inside 0..DEPTH, no wrap possible
                    if (!reject) begin
                        level_q <= (op_q == OP_PUSH) ? level_q + LW'(1) : level_q - LW'(1);
                    end
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Level vs flags is only compared in IDLE, where no stack update is pending
    assign lvl_mismatch = ((level_q == LW'(DEPTH)) != stk_full) ||
                          ((level_q == '0) != stk_empty);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perr_q <= 1'b0;
        end else if (stk_error || ((state == ST_IDLE) && lvl_mismatch)) begin
            perr_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dw_stack_arbiter.sv
// Purpose : directed bench for dw_stack_arbiter against a behavioural 8x4 stack.
// Latency : n/a.
// Backpr. : n/a.
module tb_dw_stack_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dw_stack_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    logic             busy;
    logic [2:0]       level;
    logic             stk_push_req_n;
    logic             stk_pop_req_n;
    logic [7:0]       stk_data_in;
    logic [7:0]       stk_data_out;
    logic             stk_empty;
    logic             stk_full;
    logic             stk_error;
    logic             protocol_err;

    dw_stack_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .busy           (busy),
        .level          (level),
        .stk_push_req_n (stk_push_req_n),
        .stk_pop_req_n  (stk_pop_req_n),
        .stk_data_in    (stk_data_in),
        .stk_data_out   (stk_data_out),
        .stk_empty      (stk_empty),
        .stk_full       (stk_full),
        .stk_error      (stk_error),
        .protocol_err   (protocol_err)
    );

    // Behavioural DW_stack: registered count/error, combinational top-of-stack
    logic [2:0] s_cnt;
    logic [7:0] s_mem [4];
    logic       s_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_cnt <= '0;
            s_err <= 1'b0;
        end else if (!stk_push_req_n && !stk_pop_req_n) begin
            s_err <= 1'b1;
        end else if (!stk_push_req_n) begin
            if (s_cnt == 3'd4) s_err <= 1'b1;
            else               s_cnt <= s_cnt + 3'd1;
        end else if (!stk_pop_req_n) begin
            if (s_cnt == 3'd0) s_err <= 1'b1;
            else               s_cnt <= s_cnt - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!stk_push_req_n && stk_pop_req_n && s_cnt != 3'd4)
            s_mem[s_cnt[1:0]] <= stk_data_in;
    end

    logic [2:0] s_top;
    assign s_top        = s_cnt - 3'd1;
    assign stk_data_out = (s_cnt == 3'd0) ? 8'h00 : s_mem[s_top[1:0]];
    assign stk_empty    = (s_cnt == 3'd0);
    assign stk_full     = (s_cnt == 3'd4);
    assign stk_error    = s_err;

    // Count cycles on which each stack strobe was active
    int push_low_cnt = 0;
    int pop_low_cnt  = 0;
    always @(posedge clk) begin
        if (!stk_push_req_n) push_low_cnt <= push_low_cnt + 1;
        if (!stk_pop_req_n)  pop_low_cnt  <= pop_low_cnt + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Step one clock at a time until an ack shows up, bounded
    task automatic wait_ack(input string tag);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (bus.ack == '0 && n < 20);
        n_checks++;
        assert (bus.ack !== '0) else begin
            n_fail++;
            $error("FAIL %s_timeout: observed ack %0h expected nonzero", tag, bus.ack);
        end
    endtask

    task automatic run_one(input int idx, input logic is_push, input logic [7:0] d,
                           input logic exp_err, input logic [7:0] exp_rd,
                           input logic [2:0] exp_lvl, input string tag, output time t_ack);
        logic [3:0] oh;
        oh = 4'b0001 << idx;
        bus.req[idx]            = 1'b1;
        bus.op[idx]             = is_push;
        bus.wdata[idx*8 +: 8]   = d;
        wait_ack(tag);
        t_ack = $time;
        check({tag, "_ack"},   32'(bus.ack),     32'(oh));
        check({tag, "_err"},   32'(bus.rsp_err), 32'(exp_err));
        check({tag, "_rdata"}, 32'(bus.rdata),   32'(exp_rd));
        check({tag, "_level"}, 32'(level),       32'(exp_lvl));
        bus.req[idx] = 1'b0;
    endtask

    logic [3:0] exp_order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        time t0, t1, t2, t3, tx;
        int  p0, q0;

        // ---------------- 1: reset, including reset in the middle of ISSUE
        rst       = 1'b1;
        bus.req   = '0;
        bus.op    = '0;
        bus.wdata = '0;
        #1;
        check("rst_ack",   32'(bus.ack),        32'h0);
        check("rst_level", 32'(level),          32'h0);
        check("rst_push_n",32'(stk_push_req_n), 32'h1);
        check("rst_pop_n", 32'(stk_pop_req_n),  32'h1);
        check("rst_busy",  32'(busy),           32'h0);
        check("rst_rdata", 32'(bus.rdata),      32'h0);
        check("rst_perr",  32'(protocol_err),   32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.req[0] = 1'b1; bus.op[0] = 1'b1; bus.wdata[7:0] = 8'h5A;
        @(posedge clk); #1;
        check("issue_busy",   32'(busy),           32'h1);
        check("issue_push_n", 32'(stk_push_req_n), 32'h0);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_push_n", 32'(stk_push_req_n), 32'h1);
        check("midrst_pop_n",  32'(stk_pop_req_n),  32'h1);
        check("midrst_ack",    32'(bus.ack),        32'h0);
        check("midrst_level",  32'(level),          32'h0);
        check("midrst_busy",   32'(busy),           32'h0);
        bus.req = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_no_push", 32'(push_low_cnt), 32'h0);

        // ---------------- 2: single requester push/push/pop/pop
        run_one(0, 1'b1, 8'hA1, 1'b0, 8'h00, 3'd1, "s_push_a1", t0);
        run_one(0, 1'b1, 8'hB2, 1'b0, 8'h00, 3'd2, "s_push_b2", t1);
        run_one(0, 1'b0, 8'h00, 1'b0, 8'hB2, 3'd1, "s_pop_b2",  t2);
        run_one(0, 1'b0, 8'h00, 1'b0, 8'hA1, 3'd0, "s_pop_a1",  t3);
        check("s_gap1", 32'(t1 - t0), 32'd30);
        check("s_gap2", 32'(t2 - t1), 32'd30);
        check("s_gap3", 32'(t3 - t2), 32'd30);

        // ---------------- 3: overflow
        run_one(0, 1'b1, 8'h01, 1'b0, 8'h00, 3'd1, "ov_push1", tx);
        run_one(0, 1'b1, 8'h02, 1'b0, 8'h00, 3'd2, "ov_push2", tx);
        run_one(0, 1'b1, 8'h03, 1'b0, 8'h00, 3'd3, "ov_push3", tx);
        run_one(0, 1'b1, 8'h04, 1'b0, 8'h00, 3'd4, "ov_push4", tx);
        p0 = push_low_cnt;
        run_one(0, 1'b1, 8'h05, 1'b1, 8'h00, 3'd4, "ov_push5", tx);
        check("ov_no_strobe", 32'(push_low_cnt), 32'(p0));
        check("ov_stk_err",   32'(stk_error),    32'h0);
        run_one(0, 1'b0, 8'h00, 1'b0, 8'h04, 3'd3, "ov_pop4", tx);
        run_one(0, 1'b0, 8'h00, 1'b0, 8'h03, 3'd2, "ov_pop3", tx);
        run_one(0, 1'b0, 8'h00, 1'b0, 8'h02, 3'd1, "ov_pop2", tx);
        run_one(0, 1'b0, 8'h00, 1'b0, 8'h01, 3'd0, "ov_pop1", tx);

        // ---------------- 4: underflow
        q0 = pop_low_cnt;
        run_one(1, 1'b0, 8'h00, 1'b1, 8'h00, 3'd0, "un_pop", tx);
        check("un_no_strobe", 32'(pop_low_cnt), 32'(q0));
        repeat (2) @(posedge clk);
        #1;
        check("un_perr",    32'(protocol_err), 32'h0);
        check("un_stk_err", 32'(stk_error),    32'h0);

        // ---------------- 5: fairness, all four hold push requests after reset
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        p0 = push_low_cnt;
        bus.op    = 4'hF;
        bus.wdata = 32'h34333231;
        bus.req   = 4'hF;
        for (int k = 0; k < 5; k++) begin
            wait_ack("fair");
            check("fair_ack",   32'(bus.ack),     32'(exp_order[k]));
            check("fair_err",   32'(bus.rsp_err), 32'(k == 4));
            check("fair_level", 32'(level),       (k < 4) ? 32'(k + 1) : 32'd4);
        end
        bus.req = '0;
        check("fair_strobes", 32'(push_low_cnt - p0), 32'd4);
        repeat (2) @(posedge clk);
        #1;
        check("fair_perr", 32'(protocol_err), 32'h0);

        // ---------------- 6: mixed push (req0) and pop (req2) raised together on empty stack
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.op         = 4'b0001;
        bus.wdata      = 32'h0000_0011;
        bus.req        = 4'b0101;
        wait_ack("mix_first");
        check("mix_first_ack", 32'(bus.ack),     32'h1);
        check("mix_first_err", 32'(bus.rsp_err), 32'h0);
        bus.req[0] = 1'b0;
        wait_ack("mix_second");
        check("mix_second_ack",   32'(bus.ack),     32'h4);
        check("mix_second_err",   32'(bus.rsp_err), 32'h0);
        check("mix_second_rdata", 32'(bus.rdata),   32'h11);
        check("mix_second_level", 32'(level),       32'h0);
        bus.req = '0;
        repeat (2) @(posedge clk);
        #1;
        check("mix_perr", 32'(protocol_err), 32'h0);
        check("mix_busy", 32'(busy),         32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
